section_scan_ctrl: RTL and testbench
====================================

# section_scan_ctrl

Time-multiplexed scan scheduler for the 8-section dynamic visualization driven by the buttons/LEDs Wishbone peripheral. It walks the sections in order, drives one one-hot selector line plus that section's 3-bit data with a blanking gap between sections, samples the shared return switch line during each section's slot, and debounces the result into an 8-bit per-section switch state. The Wishbone register block instantiates it and provides the enable bit and the section data registers. It reads `switch_state` back through the bus.

## Interface
- `DWELL_CYCLES`, default 50000: clocks each section is driven; must be ≥2.
- `BLANK_CYCLES`, default 500: clocks with all selectors off before each section; must be ≥1.
- `DEB_SCANS`, default 4: consecutive differing samples needed to flip a section's switch state; must be ≥1.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: scanning on/off.
- `section_data` in 24: section i data at bits [3i+2:3i].
- `switch_in` in 1: shared return line. Asynchronous to `clk`.
- `selector` out 8: one-hot, active-high section select.
- `data_out` out 3: data for the currently selected section.
- `switch_state` out 8: debounced switch state; bit i belongs to section i.
- `switch_change` out 1: one-cycle pulse when any `switch_state` bit flips.
- `frame_tick` out 1: one-cycle pulse at the end of section 7's drive slot.

## Operation
- The FSM has three states: IDLE, BLANK and DRIVE. There is a 3-bit section index `idx`, a phase counter, and per-section debounce counters of width clog2(DEB_SCANS+1).
- **IDLE:** `selector`=0, `data_out`=0, `idx`=0 and the phase counter is 0. When `enable`=1 the FSM goes to BLANK.
- **BLANK:** `selector`=0. On entry, `section_data[idx]` is captured into a data latch, and `data_out` shows the latch.
  - BLANK lasts BLANK_CYCLES clocks, then the FSM goes to DRIVE.
- **DRIVE:** `selector`=1<<idx and `data_out`=latch. DRIVE lasts DWELL_CYCLES clocks.
  - On the last DRIVE cycle, the synchronized `switch_in` is sampled for section `idx`.
  - `idx` then increments modulo 8 and the FSM goes to BLANK.
  - If `idx` was 7, `frame_tick` pulses on that same last cycle.
- **Data stability:** changes to `section_data` have no effect until the next capture, so there is no glitching mid-slot.
- **Debounce, per section i:**
  - A sample that equals `switch_state[i]` clears `cnt[i]`.
  - A sample that differs increments `cnt[i]`.
  - When the increment would reach DEB_SCANS, `switch_state[i]` toggles and `cnt[i]` clears.
- **Enable dropped in any state:** the next cycle is IDLE with `selector`=0 and `data_out`=0. The debounce counters clear, but `switch_state` is kept.
  - Re-enabling restarts at section 0 with BLANK.
- **Reset:** every output and every counter goes to 0, including `switch_state`.

## Timing
- All outputs are registered.
- `enable` is sampled high at edge N. The FSM is in BLANK from cycle N+1, and the first DRIVE cycle is N+1+BLANK_CYCLES.
- Section period is BLANK_CYCLES+DWELL_CYCLES. Frame period is 8× the section period.
- `switch_in` passes through a 2-FF synchronizer. The value seen at the sample cycle is `switch_in` from 2 clocks earlier.
- `switch_state` updates and `switch_change` pulses the cycle after the deciding sample. A change can come from at most one section per frame slot.
- If `enable` falls on the same cycle as a sample, that sample is discarded.
- If `reset` is asserted mid-frame it wins over everything.

## Configuration
- **`SCAN_BLANK_EN` defined:** BLANK phase present, as described above.
- **`SCAN_BLANK_EN` undefined:** no BLANK state and `BLANK_CYCLES` is ignored.
  - The data capture happens on DRIVE entry.
  - DRIVE follows DRIVE directly, so `selector` is contiguous.
  - Section period is DWELL_CYCLES.

## Test plan
Benches use DWELL_CYCLES=4, BLANK_CYCLES=2, DEB_SCANS=2, with the macro defined unless a line says otherwise.
- **Reset, no enable:** reset, then `enable`=0 for 20 cycles -> `selector`, `data_out`, `switch_state`, `switch_change` and `frame_tick` all stay 0.
- **Basic scan:** `section_data`=section i holds value i; `enable` rises at cycle 0 ->
  - cycles 1–2: `selector`=0.
  - cycles 3–6: `selector`=0x01, `data_out`=0.
  - cycles 9–12: `selector`=0x02, `data_out`=1.
  - `frame_tick` pulses at cycle 48, then every 48 cycles.
- **Mid-slot data change:** change section 2's data from 2 to 5 during section 2 DRIVE -> `data_out` stays 2 for the slot and shows 5 in the next frame.
- **Debounce:** hold `switch_in`=1 only during section 3 slots.
  - After the second frame: `switch_state`=0x08 with exactly one `switch_change` pulse.
  - A single-frame glitch on section 5 causes no change.
- **Enable drop and restart:** drop `enable` mid-DRIVE of section 5 -> next cycle `selector`=0 and `data_out`=0, and `switch_state`=0x08 is retained. Re-enable -> BLANK, then `selector`=0x01.
- **Macro undefined:** the scan shows `selector` stepping 0x01→0x02→… every 4 cycles with no zero gap, and `frame_tick` every 32 cycles.

Source files
------------

// File: rtl/section_scan_ctrl.sv
// section_scan_ctrl: 8-section time-multiplexed selector/data scan with per-section switch debounce.
// Define SCAN_BLANK_EN to insert an all-off blanking gap before each section's drive slot.
module section_scan_ctrl #(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int DEB_SCANS    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [23:0] section_data,
   input  logic        switch_in,
   output logic [7:0]  selector,
   output logic [2:0]  data_out,
   output logic [7:0]  switch_state,
   output logic        switch_change,
   output logic        frame_tick
);

`ifdef SCAN_BLANK_EN
   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
`else
   localparam int MAXC = DWELL_CYCLES;
`endif
   localparam int PW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int CW = $clog2(DEB_SCANS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic [2:0]          latch_q, latch_d;
   logic [7:0]          selector_q, selector_d;
   logic                frame_tick_q, frame_tick_d;
   logic [1:0]          sync_q, sync_d;
   logic [7:0]          ss_q, ss_d;
   logic                change_q, change_d;
   logic [7:0][CW-1:0]  cnt_q, cnt_d;
   logic [7:0][2:0]     sd_arr;
   logic                cap;
   logic                sample;

   assign sd_arr = section_data;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      cap     = 1'b0;
      sample  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
`ifdef SCAN_BLANK_EN
               state_d = BLANK;
`else
               state_d = DRIVE;
`endif
               idx_d   = 3'd0;
               phase_d = '0;
               cap     = 1'b1;
            end
         end
`ifdef SCAN_BLANK_EN
         BLANK: begin
            if (phase_q == PW'(BLANK_CYCLES - 1)) begin
               state_d = DRIVE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
`endif
         DRIVE: begin
            if (phase_q == PW'(DWELL_CYCLES - 1)) begin
               sample  = 1'b1;
               idx_d   = idx_q + 3'd1;
               phase_d = '0;
               cap     = 1'b1;
`ifdef SCAN_BLANK_EN
               state_d = BLANK;
`else
               state_d = DRIVE;
`endif
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Dropping enable aborts the slot and discards any sample taken on this cycle.
      if (!enable) begin
         state_d = IDLE;
         idx_d   = 3'd0;
         phase_d = '0;
         cap     = 1'b0;
         sample  = 1'b0;
      end

      latch_d = latch_q;
      if (cap) latch_d = sd_arr[idx_d];
      if (state_d == IDLE) latch_d = 3'd0;

      selector_d   = (state_d == DRIVE) ? (8'b1 << idx_d) : 8'h00;
      frame_tick_d = (state_d == DRIVE) &&
                     (phase_d == PW'(DWELL_CYCLES - 1)) &&
                     (idx_d == 3'd7);

      sync_d   = {sync_q[0], switch_in};
      ss_d     = ss_q;
      cnt_d    = cnt_q;
      change_d = 1'b0;
      if (!enable) begin
         cnt_d = '0;
      end else if (sample) begin
         if (sync_q[1] == ss_q[idx_q]) begin
            cnt_d[idx_q] = '0;
         end else if (cnt_q[idx_q] == CW'(DEB_SCANS - 1)) begin
            ss_d[idx_q]  = ~ss_q[idx_q];
            cnt_d[idx_q] = '0;
            change_d     = 1'b1;
         end else begin
            cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= 3'd0;
         phase_q      <= '0;
         latch_q      <= 3'd0;
         selector_q   <= 8'h00;
         frame_tick_q <= 1'b0;
         sync_q       <= 2'b00;
         ss_q         <= 8'h00;
         change_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         phase_q      <= phase_d;
         latch_q      <= latch_d;
         selector_q   <= selector_d;
         frame_tick_q <= frame_tick_d;
         sync_q       <= sync_d;
         ss_q         <= ss_d;
         change_q     <= change_d;
         cnt_q        <= cnt_d;
      end
   end

   assign selector      = selector_q;
   assign data_out      = latch_q;
   assign switch_state  = ss_q;
   assign switch_change = change_q;
   assign frame_tick    = frame_tick_q;

endmodule

// File: tb/tb_section_scan_ctrl.sv
// tb_section_scan_ctrl: directed bench for section_scan_ctrl (DWELL=4, BLANK=2, DEB=2).
// Expectations follow SCAN_BLANK_EN the same way the design does.
module tb_section_scan_ctrl;
   localparam int DW = 4;
   localparam int BK = 2;
`ifdef SCAN_BLANK_EN
   localparam int SP = DW + BK;
`else
   localparam int SP = DW;
`endif
   localparam int FR    = 8 * SP;
   localparam int CHG   = FR + 4 * SP + 1;
   localparam int D_CHG = 1 + 2 * SP + (SP - DW) + 1;
   localparam int DROP  = 1 + 4 * FR + 5 * SP + (SP - DW) + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [23:0] section_data;
   logic        switch_in;
   logic [7:0]  selector;
   logic [2:0]  data_out;
   logic [7:0]  switch_state;
   logic        switch_change;
   logic        frame_tick;

   int n_checks = 0;
   int n_errors = 0;
   int cur_cyc  = 0;

   always #5 clk = ~clk;

   section_scan_ctrl #(
      .DWELL_CYCLES(DW),
      .BLANK_CYCLES(BK),
      .DEB_SCANS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .section_data(section_data),
      .switch_in(switch_in),
      .selector(selector),
      .data_out(data_out),
      .switch_state(switch_state),
      .switch_change(switch_change),
      .frame_tick(frame_tick)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                  tag, cur_cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // c counts cycles after the edge that first samples enable high.
   task automatic scan_cycle(input int c, input int run);
      int sec, pos, frm;
      logic [7:0] es;
      logic [2:0] ed;
      logic       ef;
      logic [7:0] ess;
      logic       ec;
      frm = (c - 1) / FR;
      sec = ((c - 1) % FR) / SP;
      pos = (c - 1) % SP;
      es  = (pos >= SP - DW) ? (8'b1 << sec) : 8'h00;
      if (sec == 2) ed = (run == 0 && frm == 0) ? 3'd2 : 3'd5;
      else          ed = 3'(sec);
      ef  = (c % FR) == 0;
      if (run == 0) begin
         ess = (c >= CHG) ? 8'h08 : 8'h00;
         ec  = (c == CHG);
      end else begin
         ess = 8'h08;
         ec  = 1'b0;
      end
      cur_cyc = c;
      check("selector", 32'(selector), 32'(es));
      check("data_out", 32'(data_out), 32'(ed));
      check("frame_tick", 32'(frame_tick), 32'(ef));
      check("switch_state", 32'(switch_state), 32'(ess));
      check("switch_change", 32'(switch_change), 32'(ec));
      if (run == 0) begin
         switch_in = (sec == 3) || (sec == 5 && frm == 2);
         if (c == D_CHG) section_data[8:6] = 3'd5;
      end else begin
         switch_in = 1'b0;
      end
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      switch_in = 1'b0;
      for (int i = 0; i < 8; i++) section_data[3*i +: 3] = 3'(i);
      repeat (3) step();
      cur_cyc = -1;
      check("reset_outs",
            32'({selector, data_out, switch_state, switch_change, frame_tick}), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         cur_cyc = -1;
         check("idle_no_enable",
               32'({selector, data_out, switch_state, switch_change, frame_tick}), 32'h0);
      end

      enable = 1'b1;
      for (int c = 1; c <= DROP; c++) begin
         step();
         scan_cycle(c, 0);
      end

      enable    = 1'b0;
      switch_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         cur_cyc = DROP + i;
         check("drop_selector", 32'(selector), 32'h0);
         check("drop_data_out", 32'(data_out), 32'h0);
         check("drop_switch_state", 32'(switch_state), 32'h08);
         check("drop_frame_tick", 32'(frame_tick), 32'h0);
         check("drop_switch_change", 32'(switch_change), 32'h0);
      end

      enable = 1'b1;
      for (int c = 1; c <= 2 * SP + 1; c++) begin
         step();
         scan_cycle(c, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
